envia_serial: RTL and testbench
===============================

# envia_serial

UART transmitter for the board's serial link: the outbound counterpart of the serial receiver already in the design. It accepts bytes through a strobe interface into a 4-entry FIFO and shifts each one out on `TxD` as an 8N1 frame (1 start bit, 8 data bits LSB first, 1 stop bit). It sits beside the receiver in the top level, shares its 50 MHz `clk` and baud rate, and lets the design echo received characters or report note events back to the host.

## Interface
- `CLKS_PER_BIT`, 434, `clk` cycles per bit; 434 gives 115200 baud at 50 MHz. Legal range 2..65535.
- `clk`  in  1  system clock, 50 MHz
- `clr`  in  1  reset, asynchronous, active-high
- `TxD_start`  in  1  write strobe; byte on `TxD_data` is captured on every rising `clk` edge where this is high and the FIFO is not full
- `TxD_data`  in  8  byte to transmit
- `TxD`  out  1  serial line, idles high
- `TxD_busy`  out  1  high while the FIFO is non-empty or a frame is in progress
- `TxD_full`  out  1  high when the FIFO holds 4 bytes
- `TxD_overflow`  out  1  sticky; set when a write is dropped, cleared only by `clr`

## Operation
- FIFO: 4 × 8 bits, 2-bit read/write pointers that wrap modulo 4, 3-bit count (0..4).
  - Write: `TxD_start` && count < 4 → store at wptr, wptr+1.
  - Write while count == 4 → byte discarded, `TxD_overflow` set. This holds even if a pop occurs on the same edge, because `full` is evaluated from the pre-edge count.
  - Simultaneous write and pop → count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `TxD`=1. If count > 0 → pop the byte into the shift register, clear the bit counter, go to START.
  - START: `TxD`=0 for `CLKS_PER_BIT` cycles → DATA.
  - DATA: `TxD`=shift[0]. Every `CLKS_PER_BIT` cycles, shift right and increment the bit index. After bit index 7 completes → STOP.
  - STOP: `TxD`=1 for `CLKS_PER_BIT` cycles. At the end, if count > 0 → pop and go directly to START (no idle gap); else → IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1. It resets to 0 on every state entry and wraps to 0 at the terminal count. The state advances on the terminal-count cycle.
- `TxD` is driven from a register (glitch-free): the next-state value is registered.
- `TxD_busy` = (count != 0) || (state != IDLE), registered.
- `TxD_full` = (count == 4), registered.
- Reset (`clr` high, any time including mid-frame):
  - state → IDLE, `TxD` → 1, FIFO emptied (pointers and count → 0).
  - `TxD_busy`, `TxD_full`, `TxD_overflow` → 0.
  - A partially sent frame is abandoned.
  - `TxD_start` is ignored while `clr` is high.

## Timing
- `TxD_start` sampled high at edge k with an empty FIFO and state IDLE:
  - `TxD_busy` is high after edge k.
  - FSM pops at edge k+1; `TxD` falls after edge k+1.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles.
  - Start bit occupies cycles [k+1, k+1+N).
  - Data bit i occupies [k+1+N(1+i), k+1+N(2+i)), where N = `CLKS_PER_BIT`.
- Back-to-back frames: the next start bit begins on the cycle immediately after the previous stop bit's last cycle.
- `TxD_busy` falls after the edge that ends the last stop bit with the FIFO empty.
- `TxD_full` and `TxD_overflow` update on the same edge as the write that caused them.
- Throughput: one byte per 10·N cycles. The FIFO absorbs bursts of up to 4 bytes beyond the byte in flight.

## Test plan
- **Reset:** with N=4, assert `clr` mid-DATA of byte 0xA5 → `TxD`=1, `TxD_busy`=0, `TxD_full`=0, `TxD_overflow`=0 asynchronously. After release, no further bits are sent.
- **Single byte:** N=4, write 0x55 at edge k → `TxD` low for cycles k+1..k+4, then 1,0,1,0,1,0,1,0 (4 cycles each), then stop high for 4 cycles. `TxD_busy` is low after cycle k+40.
- **Burst:** N=4, write 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive edges.
  - First byte pops at once.
  - `TxD_full` rises after the 5th write.
  - A 6th write of 0xFF is dropped and sets `TxD_overflow`.
  - The line carries 5 contiguous frames in order with no idle gaps. A receiver model decodes 01..05.
- **Full + pop same edge:** fill the FIFO so that a write coincides with the STOP→START pop edge → write dropped and overflow set. Count decrements to 3.
- **Loopback:** N=434, drive `TxD` into the serial receiver, send 0x00, 0xFF, 0x3C → receiver data-ready pulses with the identical bytes.
- **Wrap-around:** 12 single writes spaced to keep ≤ 2 queued → pointers wrap 3 times. All 12 bytes are transmitted in order and `TxD_overflow` stays 0.

Source files
------------

// File: rtl/envia_serial.sv
// envia_serial: 8N1 UART transmitter with a 4-entry byte FIFO.
// Bytes written with TxD_start are queued and shifted out LSB first.
// Back-to-back frames leave no idle gap between stop and start bits.
module envia_serial #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy,
  output logic       TxD_full,
  output logic       TxD_overflow
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   baud_reg, baud_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      fifo_mem [4];
  logic [1:0]      wptr_reg, rptr_reg;
  logic [2:0]      count_reg, count_next;
  logic            txd_next;
  logic            write_en;
  logic            pop;
  logic            baud_tc;

  // A full FIFO is judged on the pre-edge count, so a write that lands on
  // the same edge as a pop is still dropped.
  assign write_en = TxD_start && (count_reg != 3'd4);
  assign baud_tc  = (baud_reg == CW'(CLKS_PER_BIT - 1));

  // FIFO storage: plain write port, no reset needed since count guards reads.
  always_ff @(posedge clk) begin
    if (write_en) begin
      fifo_mem[wptr_reg] <= TxD_data;
    end
  end

  // Next-state logic for the frame sequencer, baud counter and shifter.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_tc ? '0 : baud_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (count_reg != 3'd0) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rptr_reg];
          bit_next   = 3'd0;
          state_next = START;
        end
      end
      START: begin
        if (baud_tc) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_tc) begin
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            shift_next = {1'b0, shift_reg[7:1]};
            bit_next   = bit_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_tc) begin
          if (count_reg != 3'd0) begin
            // Chain straight into the next start bit.
            pop        = 1'b1;
            shift_next = fifo_mem[rptr_reg];
            bit_next   = 3'd0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO occupancy after this edge's write and pop.
  always_comb begin
    count_next = count_reg;
    case ({write_en, pop})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase
  end

  // Line level derived from the next state so TxD comes straight off a flop.
  always_comb begin
    txd_next = 1'b1;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  // State, FIFO pointers and registered status outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_reg      <= 3'd0;
      shift_reg    <= 8'd0;
      wptr_reg     <= 2'd0;
      rptr_reg     <= 2'd0;
      count_reg    <= 3'd0;
      TxD          <= 1'b1;
      TxD_busy     <= 1'b0;
      TxD_full     <= 1'b0;
      TxD_overflow <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      count_reg    <= count_next;
      if (write_en) begin
        wptr_reg <= wptr_reg + 2'd1;
      end
      if (pop) begin
        rptr_reg <= rptr_reg + 2'd1;
      end
      TxD          <= txd_next;
      TxD_busy     <= (count_next != 3'd0) || (state_next != IDLE);
      TxD_full     <= (count_next == 3'd4);
      TxD_overflow <= TxD_overflow | (TxD_start & (count_reg == 3'd4));
    end
  end

endmodule

// File: tb/tb_envia_serial.sv
// Testbench for envia_serial: a queue-and-timeline reference model predicts
// the line and status flags every cycle; a frame decoder recovers bytes.
module tb_envia_serial;

  localparam int NB = 4;
  localparam int NL = 434;

  logic       clk = 1'b0;
  logic       clr;
  logic       start, start2;
  logic [7:0] data, data2;
  logic       txd, busy, full, ovf;
  logic       txd2, busy2, full2, ovf2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  envia_serial #(.CLKS_PER_BIT(NB)) dut (
    .clk(clk), .clr(clr), .TxD_start(start), .TxD_data(data),
    .TxD(txd), .TxD_busy(busy), .TxD_full(full), .TxD_overflow(ovf)
  );

  envia_serial #(.CLKS_PER_BIT(NL)) dut_lb (
    .clk(clk), .clr(clr), .TxD_start(start2), .TxD_data(data2),
    .TxD(txd2), .TxD_busy(busy2), .TxD_full(full2), .TxD_overflow(ovf2)
  );

  // Reference model: pending bytes in a queue, the frame in flight described
  // by its start edge; line level is computed from elapsed time.
  logic [7:0] m_q[$];
  bit         m_frame = 1'b0;
  longint     m_t0 = 0;
  longint     m_cyc = 0;
  logic [7:0] m_cur = 8'd0;
  bit         m_ovf = 1'b0;

  always @(posedge clk or posedge clr) begin
    bit full_pre;
    if (clr) begin
      m_q.delete();
      m_frame = 1'b0;
      m_ovf   = 1'b0;
      m_cyc   = 0;
    end else begin
      full_pre = (m_q.size() == 4);
      m_cyc++;
      if (m_frame && (m_cyc == m_t0 + 10 * NB)) m_frame = 1'b0;
      if (!m_frame && (m_q.size() > 0)) begin
        m_cur   = m_q.pop_front();
        m_frame = 1'b1;
        m_t0    = m_cyc;
      end
      if (start) begin
        if (full_pre) m_ovf = 1'b1;
        else m_q.push_back(data);
      end
    end
  end

  // Expected {TxD, busy, full, overflow} after the latest edge.
  function automatic logic [3:0] exp_vec();
    logic   t;
    longint idx;
    t = 1'b1;
    if (m_frame) begin
      idx = (m_cyc - m_t0) / NB;
      if (idx == 0) t = 1'b0;
      else if (idx <= 8) t = m_cur[int'(idx - 1)];
    end
    return {t, (m_frame || (m_q.size() != 0)), (m_q.size() == 4), m_ovf};
  endfunction

  // Frame decoder over per-cycle line samples: finds start bits, samples
  // mid-bit, accepts frames whose stop bit is high.
  logic [7:0] dec_bytes[$];
  int         dec_starts[$];
  logic       samples[$];

  function automatic void decode(input logic s[$], input int n);
    int i;
    logic [7:0] b;
    dec_bytes.delete();
    dec_starts.delete();
    i = 0;
    while (i + 10 * n <= s.size()) begin
      if (s[i] === 1'b0) begin
        for (int j = 0; j < 8; j++) b[j] = s[i + n * (j + 1) + n / 2];
        if (s[i + 9 * n + n / 2] === 1'b1) begin
          dec_bytes.push_back(b);
          dec_starts.push_back(i);
        end
        i = i + 9 * n + n / 2;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic do_reset();
    start = 1'b0;
    start2 = 1'b0;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] got, exp;
    do_reset();
    vectors++;
    got = {txd, busy, full, ovf};
    if (got !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_idle: got %b expected 1000", got);
    end
    for (int i = 0; i < 10; i++) begin
      start = (i < 6);
      data  = (i == 0) ? 8'hA5 : 8'($urandom);
      @(negedge clk);
      vectors++;
      got = {txd, busy, full, ovf};
      exp = exp_vec();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_prefill cyc%0d: got %b expected %b", i, got, exp);
      end
    end
    vectors++;
    if ({full, ovf} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_before: full/ovf got %b expected 11", {full, ovf});
    end
    #2 clr = 1'b1;
    #1;
    vectors++;
    got = {txd, busy, full, ovf};
    if (got !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_async: got %b expected 1000", got);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      vectors++;
      got = {txd, busy, full, ovf};
      if (got !== 4'b1000) begin
        miscompares++;
        $display("FAIL reset_after cyc%0d: got %b expected 1000", i, got);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [3:0] got, exp;
    do_reset();
    start = 1'b1;
    data  = 8'h55;
    for (int j = 0; j < 46; j++) begin
      @(negedge clk);
      start = 1'b0;
      vectors++;
      got = {txd, busy, full, ovf};
      exp = exp_vec();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL single cyc%0d: got %b expected %b", j, got, exp);
      end
      if (j == 0 || j == 1 || j == 40 || j == 41) begin
        vectors++;
        exp[3] = (j != 1);
        exp[2] = (j != 41);
        if ({txd, busy} !== exp[3:2]) begin
          miscompares++;
          $display("FAIL single_edges cyc%0d: txd/busy got %b expected %b", j, {txd, busy}, exp[3:2]);
        end
      end
    end
  endtask

  task automatic test_burst();
    logic [3:0] got, exp;
    do_reset();
    samples.delete();
    for (int i = 0; i < 220; i++) begin
      start = (i < 6);
      data  = (i < 5) ? 8'(i + 1) : 8'hFF;
      @(negedge clk);
      samples.push_back(txd);
      vectors++;
      got = {txd, busy, full, ovf};
      exp = exp_vec();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL burst cyc%0d: got %b expected %b", i, got, exp);
      end
      if (i == 4 || i == 5) begin
        vectors++;
        if ({full, ovf} !== {1'b1, (i == 5)}) begin
          miscompares++;
          $display("FAIL burst_flags cyc%0d: full/ovf got %b expected %b", i, {full, ovf}, {1'b1, (i == 5)});
        end
      end
    end
    start = 1'b0;
    decode(samples, NB);
    vectors++;
    if (dec_bytes.size() != 5) begin
      miscompares++;
      $display("FAIL burst_count: got %0d frames expected 5", dec_bytes.size());
    end
    for (int j = 0; j < dec_bytes.size() && j < 5; j++) begin
      vectors++;
      if (dec_bytes[j] !== 8'(j + 1) || (j > 0 && dec_starts[j] - dec_starts[j-1] != 10 * NB)) begin
        miscompares++;
        $display("FAIL burst_frame%0d: got %h at %0d expected %h contiguous", j, dec_bytes[j], dec_starts[j], 8'(j + 1));
      end
    end
  endtask

  task automatic test_full_pop();
    logic [3:0] got, exp;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      start = (i < 5) || (i == 41);
      data  = 8'($urandom);
      @(negedge clk);
      vectors++;
      got = {txd, busy, full, ovf};
      exp = exp_vec();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL fullpop cyc%0d: got %b expected %b", i, got, exp);
      end
      if (i == 40 || i == 41) begin
        vectors++;
        if ({full, ovf} !== {(i == 40), (i == 41)}) begin
          miscompares++;
          $display("FAIL fullpop_edge cyc%0d: full/ovf got %b expected %b", i, {full, ovf}, {(i == 40), (i == 41)});
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] got, exp;
    logic [7:0] sent[$];
    int gap;
    do_reset();
    samples.delete();
    for (int w = 0; w < 13; w++) begin
      gap = (w < 12) ? int'($urandom_range(38, 46)) : 100;
      for (int c = 0; c < gap; c++) begin
        start = (c == 0) && (w < 12);
        data  = 8'($urandom);
        if (start) sent.push_back(data);
        @(negedge clk);
        samples.push_back(txd);
        vectors++;
        got = {txd, busy, full, ovf};
        exp = exp_vec();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL wrap w%0d c%0d: got %b expected %b", w, c, got, exp);
        end
      end
    end
    start = 1'b0;
    decode(samples, NB);
    vectors++;
    if (dec_bytes.size() != 12 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d frames ovf %b expected 12 ovf 0", dec_bytes.size(), ovf);
    end
    for (int j = 0; j < dec_bytes.size() && j < 12; j++) begin
      vectors++;
      if (dec_bytes[j] !== sent[j]) begin
        miscompares++;
        $display("FAIL wrap_byte%0d: got %h expected %h", j, dec_bytes[j], sent[j]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] got, exp;
    do_reset();
    for (int i = 0; i < 1050; i++) begin
      start = (i < 800) && ($urandom_range(0, 9) < 2);
      data  = 8'($urandom);
      @(negedge clk);
      vectors++;
      got = {txd, busy, full, ovf};
      exp = exp_vec();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %b expected %b", i, got, exp);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_loopback();
    logic [7:0] sent[3];
    sent[0] = 8'h00;
    sent[1] = 8'hFF;
    sent[2] = 8'h3C;
    do_reset();
    samples.delete();
    for (int i = 0; i < 3 * 10 * NL + 100; i++) begin
      start2 = (i < 3);
      data2  = (i < 3) ? sent[i] : 8'h00;
      @(negedge clk);
      samples.push_back(txd2);
    end
    start2 = 1'b0;
    decode(samples, NL);
    vectors++;
    if (dec_bytes.size() != 3 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL loop_count: got %0d frames busy %b expected 3 busy 0", dec_bytes.size(), busy2);
    end
    for (int j = 0; j < dec_bytes.size() && j < 3; j++) begin
      vectors++;
      if (dec_bytes[j] !== sent[j]) begin
        miscompares++;
        $display("FAIL loop_byte%0d: got %h expected %h", j, dec_bytes[j], sent[j]);
      end
    end
  endtask

  initial begin
    clr    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    data   = 8'h00;
    data2  = 8'h00;
    test_reset();
    test_single_byte();
    test_burst();
    test_full_pop();
    test_wrap();
    test_random();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
